// File: rtl/lc3b_types.sv
// Shared pipeline types: skid-stage depth and occupancy encoding.
package lc3b_types;
  localparam int PIPE_SKID_DEPTH = 2;
  typedef logic [1:0] lc3b_pipe_occ_t;
endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; clears only on synchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// 2-entry skid-buffered pipeline stage with registered in_ready.
// Perf counters built only when PIPE_STAGE_SKID_PERF_EN is defined.
module pipe_stage_skid
  import lc3b_types::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output lc3b_pipe_occ_t   occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             accept, drain;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = lc3b_pipe_occ_t'({1'b0, main_valid}) + lc3b_pipe_occ_t'({1'b0, skid_valid});
  assign accept    = in_valid && !skid_valid;
  assign drain     = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      // skid full implies in_ready=0, so a held skid entry never races a new accept
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_data <= in_data;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(main_valid && !out_ready), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush && (main_valid || skid_valid)), .cnt(flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + random bench for pipe_stage_skid against a queue-based model.
module tb_pipe_stage_skid;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, in_ready8, out_valid8;
  logic [15:0] out_data, out_data8;
  logic [1:0]  occupancy, occupancy8;
  logic [31:0] stall_cnt, flush_cnt;
  logic [7:0]  stall_cnt8, flush_cnt8;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_stage_skid #(.WIDTH(16), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .occupancy(occupancy8), .stall_cnt(stall_cnt8), .flush_cnt(flush_cnt8));

  logic [15:0] q[$];
  int unsigned stall_m = 0, flush_m = 0;
  bit          known = 0, just_rst = 0;
  int          passed = 0, total = 0;

`ifdef PIPE_STAGE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    int unsigned s8, f8;
    s8 = (stall_m > 255) ? 255 : stall_m;
    f8 = (flush_m > 255) ? 255 : flush_m;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    if (just_rst) begin
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_data8", 32'(out_data8), 32'h0);
    end
    chk("out_valid8", 32'(out_valid8), 32'(q.size() > 0));
    chk("stall_cnt",  stall_cnt, PERF ? stall_m : 32'h0);
    chk("flush_cnt",  flush_cnt, PERF ? flush_m : 32'h0);
    chk("stall_cnt8", 32'(stall_cnt8), PERF ? s8 : 32'h0);
    chk("flush_cnt8", 32'(flush_cnt8), PERF ? f8 : 32'h0);
  endtask

  // One cycle: check current outputs, drive inputs, advance the model across the edge.
  task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy,
                     input logic fl, input logic rn);
    bit ov, ir;
    if (known) check_all();
    rst_n = rn; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    ov = q.size() > 0;
    ir = q.size() < 2;
    @(posedge clk);
    just_rst = 0;
    if (!rn) begin
      q.delete(); stall_m = 0; flush_m = 0; known = 1; just_rst = 1;
    end else begin
      if (ov && !ordy) stall_m++;
      if (fl) begin
        if (q.size() > 0) flush_m++;
        q.delete();
      end else begin
        if (ov && ordy) void'(q.pop_front());
        if (iv && ir) q.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
    // Single transfer, 1-cycle latency
    cyc(1, 16'h1234, 1, 0, 1);
    cyc(0, 16'h0, 1, 0, 1);
    // Fill to 2 with downstream stalled, third push refused
    cyc(1, 16'hA000, 0, 0, 1);
    cyc(1, 16'hA001, 0, 0, 1);
    cyc(1, 16'hA002, 0, 0, 1);
    cyc(1, 16'hA002, 0, 0, 1);
    // Drain with continuous stream
    cyc(1, 16'hA002, 1, 0, 1);
    cyc(1, 16'hA003, 1, 0, 1);
    cyc(1, 16'hA004, 1, 0, 1);
    cyc(1, 16'hA005, 1, 0, 1);
    // Refill to 2 then flush with concurrent input
    cyc(1, 16'hB000, 0, 0, 1);
    cyc(1, 16'hB001, 0, 0, 1);
    cyc(1, 16'hB002, 0, 1, 1);
    cyc(0, 16'h0, 0, 0, 1);
    // Fresh reset, 10 stall cycles, then long stall for 8-bit saturation
    cyc(0, 16'h0, 0, 0, 0);
    cyc(1, 16'hC000, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 16'h0, 0, 0, 1);
    chk("stall10", stall_cnt, PERF ? 32'd10 : 32'd0);
    for (int i = 0; i < 300; i++) cyc(1, 16'(16'hC100 + i), 0, 0, 1);
    chk("stall_sat8", 32'(stall_cnt8), PERF ? 32'hFF : 32'h0);
    // Reset mid-stall at occupancy 2, with flush and input also asserted
    cyc(1, 16'hD000, 0, 1, 0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_stall", stall_cnt, 32'h0);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 9) < 7,
          $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
    check_all();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter: WIDTH, default 16, payload width in bits (1..512).
REQ-002 Parameter: CNT_W, default 32, performance counter width (8..32).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: flush  input  1  discard all held entries; synchronous.
REQ-006 Port: in_valid  input  1  upstream offers in_data.
REQ-007 Port: in_ready  output  1  stage accepts; a transfer occurs when in_valid && in_ready.
REQ-008 Port: in_data  input  WIDTH  upstream payload.
REQ-009 Port: out_valid  output  1  out_data holds a valid entry.
REQ-010 Port: out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-011 Port: out_data  output  WIDTH  head-entry payload.
REQ-012 Port: occupancy  output  2  number of held entries (0..2).
REQ-013 Port: stall_cnt  output  CNT_W  cycles with out_valid && !out_ready.
REQ-014 Port: flush_cnt  output  CNT_W  flushes that discarded at least one entry.

Function
REQ-015 The stage SHALL be a 2-entry skid buffer: a main register (feeds out_data) and a skid register.
REQ-016 in_ready SHALL be driven from a flop (= !skid_valid), with no combinational path from out_ready.
REQ-017 Latency SHALL be 1 cycle: an entry accepted at edge N is presented on out_valid/out_data after edge N.
REQ-018 Throughput SHALL be one transfer per cycle when out_ready is held high, with no bubbles.
REQ-019 When the main register is empty or being drained, an accepted entry SHALL load the main register; otherwise it SHALL load the skid register.
REQ-020 When the main register drains while the skid register is full, the skid entry SHALL move to the main register in the same cycle.
REQ-021 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-022 Entries SHALL leave in strict FIFO order, with no loss or duplication.
REQ-023 The occupancy output SHALL equal main_valid + skid_valid.
REQ-024 When flush=1, both valid bits SHALL clear at the next edge.
REQ-025 On flush, any concurrent input transfer SHALL be discarded, and flush SHALL take priority over accept and drain.
REQ-026 in_ready SHALL be 1 in the cycle after a flush.
REQ-027 With simultaneous accept and drain at occupancy 1, occupancy SHALL stay 1 and the main register SHALL take in_data.
REQ-028 in_ready SHALL be 0 only at occupancy 2; at occupancy 2 with out_ready=1, in_ready SHALL rise after the edge.
REQ-029 Payload registers SHALL update only on a load; valid bits alone SHALL define entry existence.

Reset
REQ-030 When rst_n=0 at a clock edge, main_valid, skid_valid, stall_cnt and flush_cnt SHALL all become 0.
REQ-031 When rst_n=0 at a clock edge, payload registers SHALL become 0.
REQ-032 After reset: out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-033 Reset SHALL override flush and any transfer in the same cycle, including mid-stall.

Configuration
REQ-034 When PIPE_STAGE_SKID_PERF_EN is defined, stall_cnt and flush_cnt SHALL count as specified.
REQ-035 When PIPE_STAGE_SKID_PERF_EN is defined, both counters SHALL saturate at all-ones and clear only on reset.
REQ-036 When PIPE_STAGE_SKID_PERF_EN is undefined, the counters SHALL be omitted from synthesis.
REQ-037 When PIPE_STAGE_SKID_PERF_EN is undefined, stall_cnt and flush_cnt SHALL be constant 0, and the port list SHALL be unchanged.

Structure
REQ-038 The shared lc3b_types package SHALL hold localparam PIPE_SKID_DEPTH = 2 and typedef lc3b_pipe_occ_t (logic [1:0]).
REQ-039 The perf counter SHALL be a sub-module sat_counter (params CNT_W; inputs clk, rst_n, inc), instantiated twice under the macro.
REQ-040 Existing fixed pipeline registers (e.g. ID/EX) SHALL be replaceable by this block with WIDTH = packed struct width.

Verification
REQ-041 Reset then in_valid=1, in_data=16'h1234, out_ready=1 -> out_valid=1, out_data=16'h1234 after one edge; occupancy=1.
REQ-042 out_ready=0, push 16'hA000 and 16'hA001 -> occupancy=2, in_ready=0, out_data=16'hA000 held; third push 16'hA002 not accepted.
REQ-043 From occupancy=2, set out_ready=1 for 3 cycles with a continuous stream -> output order A000, A001, then new data with no gap and no duplicate.
REQ-044 Occupancy=2 plus flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1; flush_cnt=1 (macro on) or 0 (macro off).
REQ-045 out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt=10 (macro on, CNT_W=32); with CNT_W=8 and 300 stall cycles -> stall_cnt=8'hFF.
REQ-046 rst_n=0 asserted mid-stall at occupancy 2 -> next edge out_valid=0, in_ready=1, counters=0, out_data=0.
